blake2s_round_sched: RTL and testbench

//  Sequencer for one BLAKE2s compression. On start it issues an init step, then

---
 rtl/blake2s_round_sched.sv | 88 ++++++++
 tb/tb_blake2s_round_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2s_round_sched.sv
// blake2s_round_sched: sequences init, ROUNDS x 8 G steps with SIGMA message indices, then finalise
module blake2s_round_sched #(
  parameter int ROUNDS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       last_i,
  output logic       busy_o,
  output logic       last_o,
  output logic       init_o,
  output logic       g_v_o,
  input  logic       g_ready_i,
  output logic [3:0] g_a_o,
  output logic [3:0] g_b_o,
  output logic [3:0] g_c_o,
  output logic [3:0] g_d_o,
  output logic [3:0] g_mx_o,
  output logic [3:0] g_my_o,
  output logic [3:0] round_o,
  output logic [2:0] step_o,
  output logic       fin_o,
  output logic       done_o
);
  localparam logic [1:0] IDLE = 2'd0, INIT = 2'd1, G = 2'd2, FIN = 2'd3;
  localparam logic [0:15][63:0] SIGMA = {
    64'h0123456789ABCDEF, 64'hEA489FD61C02B753, 64'hB8C052FDAE367194, 64'h7931DCBE265A40F8,
    64'h905724AFE1BC683D, 64'h2C6A0B834D75FE19, 64'hC51FED4A0763928B, 64'hDB7EC13950F4862A,
    64'h6FE9B308C2D714A5, 64'hA2847615FB9E3CD0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0
  };
  logic [1:0] state, state_n, k;
  logic [3:0] r, r_n, rm;
  logic [2:0] step, step_n;
  logic [7:0] pair;
  logic       hs, last_hs, in_g;
  always_comb begin
    hs      = state == G && g_ready_i;
    last_hs = hs && r == 4'(ROUNDS - 1) && step == 3'd7;
    state_n = state == IDLE ? (start_i ? INIT : IDLE) :
              state == INIT ? G :
              state == G    ? (last_hs ? FIN : G) : IDLE;
    r_n     = state == INIT ? 4'd0 : r + 4'(hs && step == 3'd7);
    step_n  = state == INIT ? 3'd0 : step + 3'(hs);
    rm      = r_n >= 4'd10 ? r_n - 4'd10 : r_n;
    pair    = 8'(SIGMA[rm] >> {3'd7 - step_n, 3'b000});
    k       = step_n[1:0];
    in_g    = state_n == G;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      r       <= '0;
      step    <= '0;
      busy_o  <= 1'b0;
      last_o  <= 1'b0;
      init_o  <= 1'b0;
      g_v_o   <= 1'b0;
      fin_o   <= 1'b0;
      done_o  <= 1'b0;
      g_a_o   <= '0;
      g_b_o   <= '0;
      g_c_o   <= '0;
      g_d_o   <= '0;
      g_mx_o  <= '0;
      g_my_o  <= '0;
      round_o <= '0;
      step_o  <= '0;
    end else begin
      state   <= state_n;
      r       <= r_n;
      step    <= step_n;
      busy_o  <= state_n != IDLE;
      last_o  <= state == IDLE && start_i ? last_i : last_o;
      init_o  <= state_n == INIT;
      g_v_o   <= in_g;
      fin_o   <= state_n == FIN;
      done_o  <= state == FIN;
      g_a_o   <= in_g ? {2'b00, k} : 4'd0;
      g_b_o   <= in_g ? {2'b01, step_n[2] ? k + 2'd1 : k} : 4'd0;
      g_c_o   <= in_g ? {2'b10, step_n[2] ? k + 2'd2 : k} : 4'd0;
      g_d_o   <= in_g ? {2'b11, step_n[2] ? k + 2'd3 : k} : 4'd0;
      g_mx_o  <= in_g ? pair[7:4] : 4'd0;
      g_my_o  <= in_g ? pair[3:0] : 4'd0;
      round_o <= in_g ? r_n : 4'd0;
      step_o  <= in_g ? step_n : 3'd0;
    end
  end
endmodule

// File: tb/tb_blake2s_round_sched.sv
// tb_blake2s_round_sched: directed checks of sequencing, SIGMA indices, stalls, restarts and reset
module tb_blake2s_round_sched;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic start_i = 1'b0, last_i = 1'b0, g_ready_i = 1'b0;
  logic busy_o, last_o, init_o, g_v_o, fin_o, done_o;
  logic [3:0] g_a_o, g_b_o, g_c_o, g_d_o, g_mx_o, g_my_o, round_o;
  logic [2:0] step_o;
  logic s12 = 1'b0, l12 = 1'b0, rdy12 = 1'b0;
  logic busy12, last12, init12, gv12, fin12, done12;
  logic [3:0] a12, b12, c12, d12, mx12, my12, round12;
  logic [2:0] step12;
  int tests = 0, fails = 0;
  int hs, ni, nf, nd, nb, c_init, c_fin, c_done, first_hs, last_hs, stall_bad, last_bad;
  blake2s_round_sched dut (
    .clk(clk), .reset(reset), .start_i(start_i), .last_i(last_i), .busy_o(busy_o),
    .last_o(last_o), .init_o(init_o), .g_v_o(g_v_o), .g_ready_i(g_ready_i),
    .g_a_o(g_a_o), .g_b_o(g_b_o), .g_c_o(g_c_o), .g_d_o(g_d_o), .g_mx_o(g_mx_o),
    .g_my_o(g_my_o), .round_o(round_o), .step_o(step_o), .fin_o(fin_o), .done_o(done_o)
  );
  blake2s_round_sched #(.ROUNDS(12)) dut12 (
    .clk(clk), .reset(reset), .start_i(s12), .last_i(l12), .busy_o(busy12),
    .last_o(last12), .init_o(init12), .g_v_o(gv12), .g_ready_i(rdy12),
    .g_a_o(a12), .g_b_o(b12), .g_c_o(c12), .g_d_o(d12), .g_mx_o(mx12),
    .g_my_o(my12), .round_o(round12), .step_o(step12), .fin_o(fin12), .done_o(done12)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start_and_run(input bit lst, input bit rnd, input bit extra, input int budget);
    logic [31:0] held = '0;
    bit stalled = 1'b0;
    hs = 0; ni = 0; nf = 0; nd = 0; nb = 0; stall_bad = 0; last_bad = 0;
    c_init = -1; c_fin = -1; c_done = -1; first_hs = -1; last_hs = -1;
    start_i = 1'b1;
    last_i = lst;
    for (int c = 1; c <= budget; c++) begin
      tick;
      start_i = extra && (c == 10 || c == 40);
      g_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled && {g_v_o, g_a_o, g_b_o, g_c_o, g_d_o, g_mx_o, g_my_o, round_o, step_o} !== held)
        stall_bad++;
      if (init_o) begin ni++; c_init = c; end
      if (fin_o) begin nf++; c_fin = c; end
      if (g_v_o && g_ready_i) begin
        hs++;
        if (first_hs < 0) first_hs = c;
        last_hs = c;
      end
      if (busy_o) nb++;
      if (last_o !== lst) last_bad++;
      stalled = g_v_o && !g_ready_i;
      held = {g_v_o, g_a_o, g_b_o, g_c_o, g_d_o, g_mx_o, g_my_o, round_o, step_o};
      if (done_o) begin nd++; c_done = c; break; end
    end
    start_i = 1'b0;
    g_ready_i = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    tests++;
    if ({busy_o, last_o, init_o, g_v_o, fin_o, done_o, g_a_o, g_b_o, g_c_o, g_d_o, g_mx_o, g_my_o, round_o, step_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b init=%b gv=%b fin=%b done=%b round=%0d step=%0d, want all 0", busy_o, init_o, g_v_o, fin_o, done_o, round_o, step_o);
    end
    tests++;
    if ({busy12, last12, init12, gv12, fin12, done12, a12, b12, c12, d12, mx12, my12, round12, step12} !== '0) begin
      fails++;
      $display("FAIL reset_outputs_r12: got busy=%b gv=%b done=%b, want all 0", busy12, gv12, done12);
    end
    reset = 1'b0;
    tick;
    tests++;
    if ({busy_o, init_o, g_v_o, done_o} !== 4'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%b init=%b gv=%b done=%b, want 0", busy_o, init_o, g_v_o, done_o);
    end
  endtask
  task automatic test_latency;
    start_and_run(1'b0, 1'b0, 1'b0, 200);
    tests++;
    if (c_init !== 1 || ni !== 1) begin
      fails++;
      $display("FAIL init_cycle: got cycle %0d count %0d, want cycle 1 count 1", c_init, ni);
    end
    tests++;
    if (hs !== 80 || first_hs !== 2 || last_hs !== 81) begin
      fails++;
      $display("FAIL handshakes: got %0d @%0d..%0d, want 80 @2..81", hs, first_hs, last_hs);
    end
    tests++;
    if (c_fin !== 82 || nf !== 1) begin
      fails++;
      $display("FAIL fin_cycle: got cycle %0d count %0d, want 82 count 1", c_fin, nf);
    end
    tests++;
    if (c_done !== 83) begin
      fails++;
      $display("FAIL done_cycle: got %0d, want 83", c_done);
    end
    tests++;
    if (nb !== 82 || last_bad !== 0) begin
      fails++;
      $display("FAIL busy_last: got busy cycles %0d last_o errors %0d, want 82 and 0", nb, last_bad);
    end
  endtask
  task automatic test_sigma;
    int cyc [5] = '{2, 10, 14, 31, 81};
    logic [31:0] exp_v [5] = '{32'h00048C01, 32'h10048CEA, 32'h1405AF1C, 32'h3516BC5A, 32'h97349ED0};
    logic [31:0] got;
    start_i = 1'b1;
    last_i = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      tick;
      start_i = 1'b0;
      g_ready_i = 1'b1;
      got = {round_o, 1'b0, step_o, g_a_o, g_b_o, g_c_o, g_d_o, g_mx_o, g_my_o};
      for (int k = 0; k < 5; k++)
        if (c == cyc[k]) begin
          tests++;
          if (got !== exp_v[k] || g_v_o !== 1'b1) begin
            fails++;
            $display("FAIL sigma_c%0d: got r,s,a,b,c,d,mx,my=%h gv=%b, want %h gv=1", c, got, g_v_o, exp_v[k]);
          end
        end
      if (done_o) break;
    end
    g_ready_i = 1'b0;
  endtask
  task automatic test_rounds12;
    int done_c = -1, fin_c = -1;
    logic [31:0] got;
    s12 = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      tick;
      s12 = 1'b0;
      rdy12 = 1'b1;
      got = {round12, 1'b0, step12, a12, b12, c12, d12, mx12, my12};
      if (c == 82) begin
        tests++;
        if (got !== 32'hA0048C01) begin
          fails++;
          $display("FAIL r12_row_wrap: got %h, want a0048c01", got);
        end
      end
      if (c == 97) begin
        tests++;
        if (got !== 32'hB7349E53) begin
          fails++;
          $display("FAIL r12_last_step: got %h, want b7349e53", got);
        end
      end
      if (fin12) fin_c = c;
      if (done12) begin done_c = c; break; end
    end
    rdy12 = 1'b0;
    tests++;
    if (done_c !== 99 || fin_c !== 98) begin
      fails++;
      $display("FAIL r12_done: got fin @%0d done @%0d, want fin @98 done @99", fin_c, done_c);
    end
  endtask
  task automatic test_stalls;
    start_and_run(1'b0, 1'b1, 1'b0, 3000);
    tests++;
    if (hs !== 80 || ni !== 1 || nf !== 1 || nd !== 1) begin
      fails++;
      $display("FAIL stall_counts: got hs=%0d init=%0d fin=%0d done=%0d, want 80 1 1 1", hs, ni, nf, nd);
    end
    tests++;
    if (stall_bad !== 0) begin
      fails++;
      $display("FAIL stall_stable: got %0d changes while stalled, want 0", stall_bad);
    end
  endtask
  task automatic test_ignored_start;
    start_and_run(1'b1, 1'b0, 1'b1, 200);
    tests++;
    if (ni !== 1 || hs !== 80 || c_done !== 83) begin
      fails++;
      $display("FAIL busy_start_ignored: got init=%0d hs=%0d done @%0d, want 1 80 @83", ni, hs, c_done);
    end
    tests++;
    if (last_bad !== 0) begin
      fails++;
      $display("FAIL last_held: got %0d cycles with last_o!=1, want 0", last_bad);
    end
  endtask
  task automatic test_back_to_back;
    start_and_run(1'b0, 1'b0, 1'b0, 200);
    tests++;
    if (c_init !== 1 || c_done !== 83 || last_bad !== 0) begin
      fails++;
      $display("FAIL start_on_done: got init @%0d done @%0d last errors %0d, want @1 @83 0", c_init, c_done, last_bad);
    end
  endtask
  task automatic test_mid_reset;
    int bad = 0;
    start_i = 1'b1;
    last_i = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      tick;
      start_i = 1'b0;
      g_ready_i = 1'b1;
    end
    tests++;
    if ({round_o, step_o} !== {4'd4, 3'd3}) begin
      fails++;
      $display("FAIL pre_reset_pos: got r%0d s%0d, want r4 s3", round_o, step_o);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tests++;
    if ({busy_o, last_o, init_o, g_v_o, fin_o, done_o, g_a_o, g_b_o, g_c_o, g_d_o, g_mx_o, g_my_o, round_o, step_o} !== '0) begin
      fails++;
      $display("FAIL abort_outputs: got busy=%b last=%b gv=%b round=%0d step=%0d, want all 0", busy_o, last_o, g_v_o, round_o, step_o);
    end
    for (int c = 0; c < 100; c++) begin
      tick;
      if (fin_o || done_o || busy_o) bad++;
    end
    g_ready_i = 1'b0;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL abort_quiet: got %0d cycles with fin/done/busy, want 0", bad);
    end
    start_and_run(1'b0, 1'b0, 1'b0, 200);
    tests++;
    if (c_done !== 83 || hs !== 80 || nf !== 1) begin
      fails++;
      $display("FAIL rerun_after_abort: got done @%0d hs=%0d fin=%0d, want @83 80 1", c_done, hs, nf);
    end
  endtask
  initial begin
    test_reset;
    test_latency;
    test_sigma;
    test_rounds12;
    test_stalls;
    test_ignored_start;
    test_back_to_back;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
